// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator result link: frame length, field
// offsets/widths of the packed frame {op_a, op_b, result, flags, sel} and the
// receiver FSM state type.
// -----------------------------------------------------------------------------
package calc_pkg;

    localparam int FRAME_W = 32;

    // Field offsets inside the packed frame (MSB first on the wire)
    localparam int OPA_LSB = 24;
    localparam int OPB_LSB = 16;
    localparam int RES_LSB = 8;
    localparam int FLG_LSB = 4;
    localparam int SEL_LSB = 0;

    // Field widths
    localparam int OPA_W = 8;
    localparam int OPB_W = 8;
    localparam int RES_W = 8;
    localparam int FLG_W = 4;
    localparam int SEL_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

endpackage

// File: rtl/frame_rx_fifo.sv
// -----------------------------------------------------------------------------
// frame_rx_fifo
// Synchronous FIFO buffering received frames. A push and a pop in the same
// cycle both succeed even when full; a push to a full FIFO with no pop is
// ignored (the caller reports the drop). Pointers carry one extra wrap bit.
//
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   push, din   : write request and data
//   pop         : read request (ignored when empty)
//   full, empty : status
//   head        : oldest entry (valid when ~empty)
// -----------------------------------------------------------------------------
module frame_rx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_pop;
    logic             do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_pop  = pop & ~empty;
    // A pop frees the slot being written, so a full FIFO still accepts the push.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    // Storage and pointer update
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= {PW{1'b0}};
            rd_ptr <= {PW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end else begin
                wr_ptr <= wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
            end else begin
                rd_ptr <= rd_ptr;
            end
        end
    end

endmodule

// File: rtl/frame_rx.sv
// -----------------------------------------------------------------------------
// frame_rx
// Serial receiver for the 32-bit calculator result frame. Samples dout on each
// rising edge of clk_tx (detected in the clk domain) while dout_valid is high,
// rebuilds the frame MSB first and presents it through a valid/ready handshake.
//
// Optional feature: define FRAME_RX_FIFO_EN to replace the single holding
// register with a FIFO_DEPTH-entry FIFO (frame_rx_fifo).
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   clk_tx              : divided transmit clock, used as a sample strobe only
//   dout_valid, dout    : serial frame qualifier and data (MSB first)
//   frame, op_a..sel    : received frame and its field slices
//   frame_valid/ready   : output handshake
//   abort_err           : 1-cycle pulse, frame truncated
//   overrun             : 1-cycle pulse, completed frame dropped
//   rx_busy             : high while shifting a frame
// -----------------------------------------------------------------------------
module frame_rx
    import calc_pkg::*;
#(
    parameter int WIDTH      = FRAME_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clk_tx,
    input  logic                 dout_valid,
    input  logic                 dout,
    output logic [WIDTH-1:0]     frame,
    output logic [OPA_W-1:0]     op_a,
    output logic [OPB_W-1:0]     op_b,
    output logic [RES_W-1:0]     result,
    output logic [FLG_W-1:0]     flags,
    output logic [SEL_W-1:0]     sel,
    output logic                 frame_valid,
    input  logic                 frame_ready,
    output logic                 abort_err,
    output logic                 overrun,
    output logic                 rx_busy
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
        $error("frame_rx: FIFO_DEPTH must be a power of two and at least 2");
    end

    rx_state_t        state;
    logic [5:0]       cnt;
    logic [WIDTH-1:0] sh;
    logic             clk_tx_q;
    logic             samp;
    logic             push;
    logic [WIDTH-1:0] push_data;

    assign samp      = clk_tx & ~clk_tx_q;
    assign push_data = {sh[WIDTH-2:0], dout};
    // The sample that delivers the last bit completes the frame.
    assign push      = samp & dout_valid & (state == SHIFT) & (cnt == 6'(WIDTH - 1));

    assign op_a   = frame[OPA_LSB +: OPA_W];
    assign op_b   = frame[OPB_LSB +: OPB_W];
    assign result = frame[RES_LSB +: RES_W];
    assign flags  = frame[FLG_LSB +: FLG_W];
    assign sel    = frame[SEL_LSB +: SEL_W];

    // Delay of clk_tx for rising-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_tx_q <= 1'b0;
        end else begin
            clk_tx_q <= clk_tx;
        end
    end

    // Receive FSM: shifter, bit counter, abort pulse and busy flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 6'd0;
            sh        <= {WIDTH{1'b0}};
            abort_err <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            abort_err <= 1'b0;
            if (samp) begin
                case (state)
                    IDLE: begin
                        if (dout_valid) begin
                            sh      <= push_data;
                            cnt     <= 6'd1;
                            state   <= SHIFT;
                            rx_busy <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        if (dout_valid) begin
                            sh <= push_data;
                            if (cnt == 6'(WIDTH - 1)) begin
                                cnt     <= 6'd0;
                                state   <= IDLE;
                                rx_busy <= 1'b0;
                            end else begin
                                cnt <= cnt + 6'd1;
                            end
                        end else begin
                            // Qualifier dropped mid-frame: discard the partial frame.
                            abort_err <= 1'b1;
                            sh        <= {WIDTH{1'b0}};
                            cnt       <= 6'd0;
                            state     <= IDLE;
                            rx_busy   <= 1'b0;
                        end
                    end
                    default: begin
                        cnt     <= 6'd0;
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef FRAME_RX_FIFO_EN
    logic fifo_full;
    logic fifo_empty;
    logic fifo_pop;

    assign fifo_pop    = frame_ready & ~fifo_empty;
    assign frame_valid = ~fifo_empty;

    frame_rx_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (frame_ready),
        .din   (push_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (frame)
    );

    // Overrun pulse: push into a full FIFO that is not popped this cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else begin
            overrun <= push & fifo_full & ~fifo_pop;
        end
    end
`else
    // Single holding register with overrun detection
    always_ff @(posedge clk) begin
        if (reset) begin
            frame       <= {WIDTH{1'b0}};
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (push) begin
                if (!frame_valid || frame_ready) begin
                    frame       <= push_data;
                    frame_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_frame_rx
// Self-checking bench for frame_rx. The bench acts as the serial transmitter
// and keeps a queue-based reference of the output stage (capacity 1, or 4 with
// FRAME_RX_FIFO_EN); DUT outputs are compared every falling clk edge.
// -----------------------------------------------------------------------------
module tb_frame_rx;
    import calc_pkg::*;

`ifdef FRAME_RX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic        clk;
    logic        reset;
    logic        clk_tx;
    logic        dout_valid;
    logic        dout;
    logic [31:0] frame;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [7:0]  result;
    logic [3:0]  flags;
    logic [3:0]  sel;
    logic        frame_valid;
    logic        frame_ready;
    logic        abort_err;
    logic        overrun;
    logic        rx_busy;

    frame_rx #(
        .WIDTH      (32),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clk_tx      (clk_tx),
        .dout_valid  (dout_valid),
        .dout        (dout),
        .frame       (frame),
        .op_a        (op_a),
        .op_b        (op_b),
        .result      (result),
        .flags       (flags),
        .sel         (sel),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .abort_err   (abort_err),
        .overrun     (overrun),
        .rx_busy     (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] exp_q[$];
    logic        exp_abort;
    logic        exp_ovr;
    logic        push_pend;
    logic        abort_pend;
    logic [31:0] push_word;
    bit          mon_en;
    bit          m_pop;

    // Output stage as a bounded queue: pop first, then accept push if room.
    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
            exp_abort = 1'b0;
            exp_ovr   = 1'b0;
        end else begin
            m_pop     = frame_ready && (exp_q.size() > 0);
            exp_abort = abort_pend;
            exp_ovr   = 1'b0;
            if (m_pop) void'(exp_q.pop_front());
            if (push_pend) begin
                if (exp_q.size() < CAP) exp_q.push_back(push_word);
                else exp_ovr = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (mon_en) begin
            chk("frame_valid", frame_valid, exp_q.size() != 0);
            chk("abort_err", abort_err, exp_abort);
            chk("overrun", overrun, exp_ovr);
            if (exp_q.size() != 0) begin
                chk("frame", frame, exp_q[0]);
                chk("op_a", op_a, exp_q[0][31:24]);
                chk("op_b", op_b, exp_q[0][23:16]);
                chk("result", result, exp_q[0][15:8]);
                chk("flags", flags, exp_q[0][7:4]);
                chk("sel", sel, exp_q[0][3:0]);
            end
        end
    end

    // ---------------- transmitter ----------------
    bit rnd_ready;

    task automatic tick();
        @(negedge clk);
        push_pend  = 1'b0;
        abort_pend = 1'b0;
        // Between strobes the line carries noise that must be ignored.
        dout       = 1'($urandom);
        dout_valid = 1'($urandom);
        if (rnd_ready) frame_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic strobe(input logic d, input logic dv, input bit last, input bit abrt,
                          input int hi, input int lo, input logic [31:0] w, input bit force_rdy);
        tick();
        clk_tx     = 1'b1;
        dout       = d;
        dout_valid = dv;
        push_pend  = last;
        abort_pend = abrt;
        push_word  = w;
        if (force_rdy) frame_ready = 1'b1;
        repeat (hi - 1) tick();
        tick();
        clk_tx = 1'b0;
        if (force_rdy) frame_ready = 1'b0;
        repeat (lo - 1) tick();
    endtask

    task automatic send_frame(input logic [31:0] w, input int hi, input int lo, input bit force_rdy);
        for (int i = 31; i >= 0; i--) begin
            strobe(w[i], 1'b1, i == 0, 1'b0, hi, lo, w, force_rdy && (i == 0));
        end
    endtask

    task automatic send_bits(input logic [31:0] w, input int n, input int hi, input int lo);
        for (int i = 31; i > 31 - n; i--) begin
            strobe(w[i], 1'b1, 1'b0, 1'b0, hi, lo, w, 1'b0);
        end
    endtask

    task automatic send_abort(input logic [31:0] w, input int n, input int hi, input int lo);
        send_bits(w, n, hi, lo);
        strobe(1'b0, 1'b0, 1'b0, 1'b1, hi, lo, w, 1'b0);
    endtask

    task automatic gap(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) strobe(1'($urandom), 1'b0, 1'b0, 1'b0, hi, lo, 32'h0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] W1 = {8'h07, 8'h08, 8'h0F, 4'h0, 4'h1};
    localparam logic [31:0] W2 = {8'h1F, 8'h1F, 8'h3E, 4'h0, 4'h2};

    initial begin
        int hi;
        int lo;
        int kind;
        reset       = 1'b1;
        clk_tx      = 1'b0;
        dout        = 1'b0;
        dout_valid  = 1'b0;
        frame_ready = 1'b0;
        push_pend   = 1'b0;
        abort_pend  = 1'b0;
        push_word   = 32'h0;
        rnd_ready   = 1'b0;
        mon_en      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_frame", frame, 32'h0);
        chk("rst_valid", frame_valid, 1'b0);
        chk("rst_busy", rx_busy, 1'b0);
        chk("rst_abort", abort_err, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Single frame at the fastest rate
        frame_ready = 1'b0;
        send_frame(W1, 1, 1, 1'b0);
        idle(3);
        frame_ready = 1'b1;
        idle(3);

        // Back-to-back frames, consumer always ready
        send_frame(W1, 1, 1, 1'b0);
        send_frame(W2, 1, 1, 1'b0);
        idle(4);

        // Truncated frame after 12 bits, then a clean frame
        send_abort(32'hDEADBEEF, 12, 1, 1);
        send_frame(W2, 1, 2, 1'b0);
        idle(4);

        // Consumer stalled across five frames, then drained
        frame_ready = 1'b0;
        for (int k = 0; k < 5; k++) send_frame(32'hA0B0C000 + 32'(k), 1, 1, 1'b0);
        idle(3);
        frame_ready = 1'b1;
        idle(8);

        // Fill the output stage, then push and pop in the same cycle
        frame_ready = 1'b0;
        for (int k = 0; k < CAP; k++) send_frame(32'h11110000 + 32'(k), 1, 1, 1'b0);
        send_frame(32'h5A5A5A5A, 1, 1, 1'b1);
        idle(3);
        frame_ready = 1'b1;
        idle(8);

        // Reset in the middle of a frame while a frame is held
        frame_ready = 1'b0;
        send_frame(W1, 1, 1, 1'b0);
        send_bits(32'hCAFEF00D, 20, 1, 1);
        chk("busy_midframe", rx_busy, 1'b1);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        chk("rst2_frame", frame, 32'h0);
        chk("rst2_valid", frame_valid, 1'b0);
        chk("rst2_busy", rx_busy, 1'b0);
        chk("rst2_abort", abort_err, 1'b0);
        chk("rst2_overrun", overrun, 1'b0);
        frame_ready = 1'b1;
        send_frame(W2, 1, 1, 1'b0);
        idle(4);

        // Randomized traffic, rates and consumer behaviour
        rnd_ready = 1'b1;
        for (int it = 0; it < 40; it++) begin
            hi   = $urandom_range(1, 2);
            lo   = $urandom_range(1, 3);
            kind = $urandom_range(0, 7);
            if (kind <= 5) send_frame($urandom, hi, lo, 1'b0);
            else if (kind == 6) send_abort($urandom, $urandom_range(1, 31), hi, lo);
            else gap($urandom_range(1, 3), hi, lo);
        end
        rnd_ready   = 1'b0;
        frame_ready = 1'b1;
        idle(10);
        chk("drained", frame_valid, 1'b0);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
